quad_updown_decoder: RTL

QUAD_UPDOWN_DECODER -- requirements
Module: quad_updown_decoder

---
 rtl/quad_updown_decoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/quad_updown_decoder.sv
// quad_updown_decoder
//   Quadrature (A/B) decoder producing registered up/down step pulses and a
//   local modulo-16 position count with wrap carry and a sticky error flag for
//   illegal (double-bit) transitions.
//
// Ports
//   clk      : sole clock, rising edge
//   rst      : asynchronous, active-high reset
//   a, b     : quadrature phases, asynchronous to clk
//   en       : step enable; steps are discarded while low
//   err_clr  : synchronous clear of err
//   up, down : one-cycle registered step pulses (forward / reverse)
//   count    : position count, modulo 16
//   carry    : one-cycle pulse when count wraps (15->0 on up, 0->15 on down)
//   err      : sticky illegal-transition flag
//
// State | meaning
// INIT  | synchronizer refilling after reset; {ap,bp} loaded each edge, no decode
// TRACK | {ap,bp} loaded each edge, transitions decoded into steps
module quad_updown_decoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       en,
    input  logic       err_clr,
    output logic       up,
    output logic       down,
    output logic [3:0] count,
    output logic       carry,
    output logic       err
);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic                   as, bs;
    logic                   ap, bp;
    logic [2:0]             init_cnt, init_cnt_nxt;
    logic                   fwd, rev, illegal;
    logic                   step_up, step_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b};
        end
    end

    assign as = a_sync[SYNC_STAGES-1];
    assign bs = b_sync[SYNC_STAGES-1];

    // The synchronizer is cleared by reset, so right after release its output
    // still shows the cleared value and not the pins. INIT therefore stays
    // until the first real sample has reached {as,bs} and been loaded into
    // {ap,bp}: SYNC_STAGES+1 edges, timed by a down-counter. Decoding sooner
    // would see a fake 00 -> pins transition.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        fwd          = 1'b0;
        rev          = 1'b0;
        illegal      = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == 3'd0) begin
                    state_nxt = TRACK;
                end else begin
                    init_cnt_nxt = init_cnt - 3'd1;
                end
            end
            TRACK: begin
                case ({ap, bp, as, bs})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: rev = 1'b1;
                    default: ;
                endcase
                illegal = (ap ^ as) & (bp ^ bs);
            end
            default: state_nxt = INIT;
        endcase
    end

    assign step_up = fwd & en;
    assign step_dn = rev & en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= 3'(SYNC_STAGES);
            ap       <= 1'b0;
            bp       <= 1'b0;
            up       <= 1'b0;
            down     <= 1'b0;
            count    <= 4'd0;
            carry    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            // Previous pair tracks regardless of en so enabling never
            // produces a stale step.
            ap       <= as;
            bp       <= bs;
            up       <= step_up;
            down     <= step_dn;
            carry    <= (step_up && count == 4'd15) || (step_dn && count == 4'd0);
            if (step_up) begin
                count <= count + 4'd1;
            end else if (step_dn) begin
                count <= count - 4'd1;
            end
            // A new illegal transition takes priority over a clear.
            err      <= illegal | (err & ~err_clr);
        end
    end

endmodule
